// File: rtl/cpu_net_iface_if.sv
// CPU/router handshake bundle for one tile's network interface.
// slave is the interface block, master is the CPU/router side.
interface cpu_net_iface_if #(
  parameter int LW = 3
);
  logic [31:0]   tx_data;
  logic [15:0]   tx_dst_x;
  logic [15:0]   tx_dst_y;
  logic          tx_valid;
  logic          tx_ready;
  logic [63:0]   flit_out;
  logic          flit_out_valid;
  logic          flit_out_ready;
  logic [63:0]   flit_in;
  logic          flit_in_valid;
  logic          flit_in_ready;
  logic [31:0]   rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [LW-1:0] tx_level;
  logic [LW-1:0] rx_level;
  logic [7:0]    drop_cnt;

  modport slave (
    input  tx_data, tx_dst_x, tx_dst_y,
    input  tx_valid, flit_out_ready,
    input  flit_in, flit_in_valid, rx_ready,
    output tx_ready, flit_out, flit_out_valid,
    output flit_in_ready, rx_data, rx_valid,
    output tx_level, rx_level, drop_cnt
  );

  modport master (
    output tx_data, tx_dst_x, tx_dst_y,
    output tx_valid, flit_out_ready,
    output flit_in, flit_in_valid, rx_ready,
    input  tx_ready, flit_out, flit_out_valid,
    input  flit_in_ready, rx_data, rx_valid,
    input  tx_level, rx_level, drop_cnt
  );
endinterface

// File: rtl/cpu_net_iface.sv
// Tile network interface: packs CPU words into flits (TX FIFO),
// filters and unpacks router flits for the CPU (RX FIFO).
module cpu_net_iface #(
  parameter logic [15:0] LOCAL_X = 16'h0001,
  parameter logic [15:0] LOCAL_Y = 16'h0001,
  parameter int          DEPTH   = 4
) (
  input logic         clk,
  input logic         rst,
  cpu_net_iface_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] data;
  } flit_t;

  flit_t         tx_mem [DEPTH];
  logic [31:0]   rx_mem [DEPTH];
  logic [AW-1:0] tx_wp, tx_rp;
  logic [AW-1:0] rx_wp, rx_rp;
  logic [LW-1:0] tx_cnt, rx_cnt;
  logic [7:0]    drops;
  flit_t         fin;
  logic          tx_push, tx_pop;
  logic          rx_acc, rx_local;
  logic          rx_push, rx_pop;

  // handshakes depend only on registered levels
  assign bus.tx_ready       = (tx_cnt != FULL);
  assign bus.flit_out_valid = (tx_cnt != '0);
  assign bus.flit_in_ready  = (rx_cnt != FULL);
  assign bus.rx_valid       = (rx_cnt != '0);

  assign bus.flit_out = bus.flit_out_valid
                      ? tx_mem[tx_rp] : '0;
  assign bus.rx_data  = bus.rx_valid
                      ? rx_mem[rx_rp] : '0;

  assign bus.tx_level = tx_cnt;
  assign bus.rx_level = rx_cnt;
  assign bus.drop_cnt = drops;

  assign fin      = flit_t'(bus.flit_in);
  assign tx_push  = bus.tx_valid && bus.tx_ready;
  assign tx_pop   = bus.flit_out_valid
                 && bus.flit_out_ready;
  assign rx_acc   = bus.flit_in_valid
                 && bus.flit_in_ready;
  assign rx_local = (fin.x == LOCAL_X)
                 && (fin.y == LOCAL_Y);
  assign rx_push  = rx_acc && rx_local;
  assign rx_pop   = bus.rx_valid && bus.rx_ready;

  // FIFO storage, intentionally not cleared by reset
  always_ff @(posedge clk) begin
    if (tx_push)
      tx_mem[tx_wp] <= {bus.tx_dst_x,
                        bus.tx_dst_y,
                        bus.tx_data};
    if (rx_push)
      rx_mem[rx_wp] <= fin.data;
  end

  // TX pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + LW'(1);
        2'b01:   tx_cnt <= tx_cnt - LW'(1);
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  // RX pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + LW'(1);
        2'b01:   rx_cnt <= rx_cnt - LW'(1);
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // saturating count of accepted flits for other tiles
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      drops <= '0;
    else if (rx_acc && !rx_local && drops != 8'hFF)
      drops <= drops + 8'd1;
  end
endmodule

// File: doc/cpu_net_iface.md
# cpu_net_iface

Network interface between one CPU tile and its mesh router in the 3x3 CPU/router network. It packs 32-bit CPU payloads with a destination (x, y) into 64-bit flits, buffers them in a transmit FIFO, and hands them to the router's CPU-side input. On the return path it accepts 64-bit flits from the router's CPU-side output, filters out flits not addressed to this tile, buffers the rest in a receive FIFO, and presents the 32-bit payloads to the CPU. Both directions use valid/ready handshakes, so neither the CPU nor the router has to be sampled every cycle.

## Interface
Parameters:
- LOCAL_X, 16'h0001, x coordinate of this tile (1..3 in the mesh)
- LOCAL_Y, 16'h0001, y coordinate of this tile
- DEPTH, 4, entries per FIFO; power of two, minimum 2

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  reset, asynchronous, active-high
- tx_data  in  32  CPU payload
- tx_dst_x  in  16  destination x
- tx_dst_y  in  16  destination y
- tx_valid  in  1  CPU offers a word
- tx_ready  out  1  transmit FIFO can accept a word
- flit_out  out  64  flit to the router
- flit_out_valid  out  1  flit_out is valid
- flit_out_ready  in  1  router consumes flit_out
- flit_in  in  64  flit from the router
- flit_in_valid  in  1  flit_in is valid
- flit_in_ready  out  1  receive FIFO can accept a flit
- rx_data  out  32  payload delivered to the CPU
- rx_valid  out  1  rx_data is valid
- rx_ready  in  1  CPU consumes rx_data
- tx_level  out  log2(DEPTH)+1  occupancy of the transmit FIFO
- rx_level  out  log2(DEPTH)+1  occupancy of the receive FIFO
- drop_cnt  out  8  count of misrouted flits, saturating

## Operation
- Flit format: [63:48] destination x, [47:32] destination y, [31:0] payload.
- TX push: when tx_valid && tx_ready, write {tx_dst_x, tx_dst_y, tx_data} at the write pointer.
  - tx_ready = (tx_level != DEPTH).
  - The block does no local-destination loopback. A word addressed to (LOCAL_X, LOCAL_Y) is sent to the router like any other.
- TX pop: when flit_out_valid && flit_out_ready, advance the read pointer.
  - flit_out_valid = (tx_level != 0).
  - flit_out is the head entry (show-ahead), and is forced to 64'h0 while flit_out_valid = 0.
- RX accept: a flit is accepted when flit_in_valid && flit_in_ready.
  - flit_in_ready = (rx_level != DEPTH). It never depends on flit contents.
- Address filter on an accepted flit:
  - If [63:48] == LOCAL_X and [47:32] == LOCAL_Y, write [31:0] into the receive FIFO.
  - Otherwise discard the flit and increment drop_cnt. drop_cnt saturates at 8'hFF.
- RX pop: when rx_valid && rx_ready, advance the read pointer.
  - rx_valid = (rx_level != 0).
  - rx_data is the head entry, forced to 32'h0 while rx_valid = 0.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. Levels are tracked with counters: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Simultaneous push and pop on a non-empty, non-full FIFO: both happen and the level is unchanged.
- Full FIFO: push is refused because ready = 0, even if a pop happens in the same cycle. There is no same-cycle bypass.
- Empty FIFO: a pop cannot happen because valid = 0. A push and a pop request in the same cycle results in the push only.
- Reset, at any time including mid-transfer:
  - Pointers, levels and drop_cnt go to 0.
  - Buffered words are lost; memory contents are not cleared.
  - Outputs after reset: tx_ready=1, flit_in_ready=1, flit_out_valid=0, flit_out=0, rx_valid=0, rx_data=0, tx_level=0, rx_level=0, drop_cnt=0.

## Timing
- Latency from tx_valid&&tx_ready at edge N to flit_out_valid: high after edge N, so the flit is offered in cycle N+1.
- Latency from an accepted local flit at edge N to rx_valid: high after edge N.
- Ready and valid outputs are functions of registered levels only; there is no combinational path from any input to any ready or valid output.
- The flit_out and rx_data muxes are combinational from registered state only.
- Throughput: one word per cycle per direction, sustained, when the consumer holds ready = 1.

## Test plan
- Reset, then push 3 words (tx_data 0x11, 0x22, 0x33 to dst (2,1)) with flit_out_ready=0 -> tx_level=3 and flit_out=64'h0002_0001_0000_0011. Then set flit_out_ready=1 -> flits emerge in order 0x11, 0x22, 0x33 on consecutive cycles, then flit_out_valid=0 and flit_out=0.
- Fill TX to DEPTH=4 with flit_out_ready=0 -> tx_ready=0, and a 5th tx_valid is not stored. Then pop and push in the same cycle -> tx_level stays at 3 and the order is preserved across pointer wrap.
- LOCAL=(1,1). Send flit_in 64'h0001_0001_DEAD_BEEF and then 64'h0003_0001_0000_0005 -> rx_data=0xDEADBEEF with rx_level=1, the second flit is dropped, and drop_cnt=1.
- Send 300 misrouted flits -> drop_cnt saturates at 8'hFF and rx_level stays 0.
- With rx_ready=0, send 4 local flits -> flit_in_ready=0 and a 5th flit (even a misrouted one) is not accepted and not counted. Then rx_ready=1 -> payloads are delivered in order.
- Assert rst mid-stream with TX=2 and RX=3 -> all outputs take their reset values immediately (asynchronously), and traffic resumes correctly after release.
